// File: rtl/wbmem_pkg.sv
// Shared FSM state encoding and byte-lane select constants for the Wishbone/memory bridge.
package wbmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    XFER = 2'd2,
    ACK  = 2'd3
  } state_t;

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_LO   = 2'b01;
  localparam logic [1:0] SEL_HI   = 2'b10;
  localparam logic [1:0] SEL_WORD = 2'b11;

endpackage

// File: rtl/wb_sim_mem_bridge_if.sv
// Wishbone classic slave bus plus the flat memory-model port driven by the bridge.
interface wb_sim_mem_bridge_if;

  logic [19:1] wb_adr_i;
  logic [1:0]  wb_sel_i;
  logic [15:0] wb_dat_i;
  logic [15:0] wb_dat_o;
  logic        wb_we_i;
  logic        wb_stb_i;
  logic        wb_cyc_i;
  logic        wb_ack_o;
  logic [19:0] mem_addr;
  logic [15:0] mem_wr_data;
  logic [15:0] mem_rd_data;
  logic        mem_we;
  logic        mem_byte_m;

  // Bridge side: Wishbone slave, memory master.
  modport slave (
    input  wb_adr_i, wb_sel_i, wb_dat_i, wb_we_i, wb_stb_i, wb_cyc_i, mem_rd_data,
    output wb_dat_o, wb_ack_o, mem_addr, mem_wr_data, mem_we, mem_byte_m
  );

  // CPU plus memory-model side.
  modport master (
    output wb_adr_i, wb_sel_i, wb_dat_i, wb_we_i, wb_stb_i, wb_cyc_i, mem_rd_data,
    input  wb_dat_o, wb_ack_o, mem_addr, mem_wr_data, mem_we, mem_byte_m
  );

endinterface

// File: rtl/wbmem_lane_steer.sv
// Combinational byte-lane steering: Wishbone select -> memory address LSB, access size and data lanes.
module wbmem_lane_steer
  import wbmem_pkg::*;
(
  input  logic [1:0]  sel,
  input  logic [15:0] wr_dat,
  input  logic [15:0] rd_dat,
  output logic        addr_lsb,
  output logic        byte_m,
  output logic        access,
  output logic [15:0] wr_lanes,
  output logic [15:0] rd_lanes
);

  always_comb begin
    addr_lsb = 1'b0;
    byte_m   = 1'b0;
    access   = 1'b1;
    wr_lanes = wr_dat;
    rd_lanes = rd_dat;
    // Byte reads come back sign-extended from memory; only rd_dat[7:0] is meaningful.
    case (sel)
      SEL_LO: begin
        byte_m   = 1'b1;
        wr_lanes = {8'h00, wr_dat[7:0]};
        rd_lanes = {8'h00, rd_dat[7:0]};
      end
      SEL_HI: begin
        addr_lsb = 1'b1;
        byte_m   = 1'b1;
        wr_lanes = {8'h00, wr_dat[15:8]};
        rd_lanes = {rd_dat[7:0], 8'h00};
      end
      SEL_NONE: begin
        access   = 1'b0;
        wr_lanes = 16'h0000;
        rd_lanes = 16'h0000;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/wb_sim_mem_bridge.sv
// Wishbone B3 classic slave driving the simulation memory model with programmable wait states.
// Define WBMEM_STATS_EN to add the rd_cnt/wr_cnt completed-transfer counters.
module wb_sim_mem_bridge
  import wbmem_pkg::*;
#(
  parameter int WAIT_STATES = 1,
  parameter int CNT_W       = 32
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  wb_sim_mem_bridge_if.slave bus
`ifdef WBMEM_STATS_EN
  ,
  output logic [CNT_W-1:0]   rd_cnt,
  output logic [CNT_W-1:0]   wr_cnt
`endif
);

  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t      state_reg;
  logic [3:0]  wait_cnt_reg;
  logic [1:0]  sel_reg;
  logic        we_reg;

  logic        addr_lsb;
  logic        byte_m;
  logic        access;
  logic [15:0] wr_lanes;
  logic [15:0] rd_lanes;
  logic [1:0]  steer_sel;

  // Live select while idle (request capture), latched select afterwards (read return, write enable).
  assign steer_sel = (state_reg == IDLE) ? bus.wb_sel_i : sel_reg;

  wbmem_lane_steer u_steer (
    .sel      (steer_sel),
    .wr_dat   (bus.wb_dat_i),
    .rd_dat   (bus.mem_rd_data),
    .addr_lsb (addr_lsb),
    .byte_m   (byte_m),
    .access   (access),
    .wr_lanes (wr_lanes),
    .rd_lanes (rd_lanes)
  );

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_reg       <= IDLE;
      wait_cnt_reg    <= 4'd0;
      sel_reg         <= SEL_NONE;
      we_reg          <= 1'b0;
      bus.wb_ack_o    <= 1'b0;
      bus.wb_dat_o    <= 16'h0000;
      bus.mem_we      <= 1'b0;
      bus.mem_addr    <= 20'h00000;
      bus.mem_wr_data <= 16'h0000;
      bus.mem_byte_m  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.wb_cyc_i && bus.wb_stb_i && !bus.wb_ack_o) begin
            sel_reg         <= bus.wb_sel_i;
            we_reg          <= bus.wb_we_i;
            bus.mem_addr    <= {bus.wb_adr_i, addr_lsb};
            bus.mem_byte_m  <= byte_m;
            bus.mem_wr_data <= wr_lanes;
            if (WAIT_STATES == 0) begin
              state_reg  <= XFER;
              bus.mem_we <= bus.wb_we_i & access;
            end else begin
              state_reg    <= WAIT;
              wait_cnt_reg <= WAIT_LOAD;
            end
          end
        end
        WAIT: begin
          if (!bus.wb_cyc_i) begin
            state_reg <= IDLE;
          end else if (wait_cnt_reg == 4'd0) begin
            state_reg  <= XFER;
            bus.mem_we <= we_reg & access;
          end else begin
            wait_cnt_reg <= wait_cnt_reg - 4'd1;
          end
        end
        XFER: begin
          bus.mem_we <= 1'b0;
          if (!bus.wb_cyc_i) begin
            state_reg <= IDLE;
          end else begin
            state_reg    <= ACK;
            bus.wb_ack_o <= 1'b1;
            if (!we_reg) bus.wb_dat_o <= rd_lanes;
          end
        end
        ACK: begin
          bus.wb_ack_o <= 1'b0;
          state_reg    <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef WBMEM_STATS_EN
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      rd_cnt <= '0;
      wr_cnt <= '0;
    end else if (state_reg == ACK) begin
      if (we_reg) wr_cnt <= wr_cnt + CNT_W'(1);
      else        rd_cnt <= rd_cnt + CNT_W'(1);
    end
  end
`endif

endmodule
